// File: rtl/mem_bus_unit.sv
// mem_bus_unit - MEM-stage data bus unit.
//
// Takes one instruction per cycle from the EX/MEM register. ALU results
// go straight to WB one cycle later. Loads and stores run one request/
// acknowledge cycle on the external data bus (DAD/DDT/MREQ/WRITE/SIZE,
// ACKD_n active low), aligning store data onto byte lanes and
// extracting/extending load data. Upstream stages are stalled while a
// bus cycle is being accepted or is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a REQ that sees no acknowledge for TIMEOUT cycles is
//               abandoned and bus_err pulses for one cycle.
//   undefined : REQ waits indefinitely, bus_err is tied 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid/load/store/size/sign instruction from EX/MEM
//   ex_addr, ex_wdata, ex_result  address, store data, ALU result
//   ex_rd                         destination register
//   mem_stall                     hold IF/ID/EX
//   wb_valid, wb_rd, wb_data      result to WB (one-cycle pulse)
//   misalign                      one-cycle pulse, access rejected
//   bus_err                       one-cycle pulse, bus timeout
//   DAD, DDT, MREQ, WRITE, SIZE   external data bus
//   ACKD_n                        bus acknowledge, active low
module mem_bus_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_sign,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_result,
  input  logic [4:0]  ex_rd,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  input  logic        ACKD_n
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Registered access attributes, held stable for the whole bus cycle.
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic        write_reg;
  logic [4:0]  rd_reg;

  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic        misalign_reg;

  // Per-cycle decisions from the FSM.
  logic accept;
  logic alu_pass;
  logic mis_pulse;
  logic ack_done;

  // ---------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------
  logic is_mem;
  logic is_byte;
  logic is_half;
  logic misaligned;

  assign is_mem  = ex_load | ex_store;
  assign is_byte = (ex_size == 2'b10);
  assign is_half = (ex_size == 2'b01);
  // Size 11 falls into the word case.
  assign misaligned = is_half ? ex_addr[0] :
                      is_byte ? 1'b0 :
                                (ex_addr[1:0] != 2'b00);

  // Store data replicated across lanes so that the addressed lane always
  // carries the right bytes, whatever addr[1:0] is.
  logic [31:0] store_lanes;
  always_comb begin
    store_lanes = ex_wdata;
    if (is_byte) begin
      store_lanes = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      store_lanes = {2{ex_wdata[15:0]}};
    end
  end

  // ---------------------------------------------------------------
  // Optional timeout counter
  // ---------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_reg;
  logic          timeout_tick;
  logic          timeout_hit;
  logic          bus_err_reg;

  // Counter holds (k-1) during the k-th REQ cycle, so the tick lands on
  // the edge that closes the TIMEOUT-th REQ cycle.
  assign timeout_tick = (tmo_cnt_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == REQ) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= timeout_hit;
    end
  end

  assign bus_err = bus_err_reg;
`else
  assign bus_err = 1'b0;
`endif

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    alu_pass   = 1'b0;
    mis_pulse  = 1'b0;
    ack_done   = 1'b0;
    mem_stall  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        // An acknowledge seen here belongs to nobody and is ignored.
        if (ex_valid) begin
          if (!is_mem) begin
            alu_pass = 1'b1;
          end else if (misaligned) begin
            mis_pulse = 1'b1;
          end else begin
            accept     = 1'b1;
            mem_stall  = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (!ACKD_n) begin
          // An ack on the timeout edge still completes normally.
          ack_done   = 1'b1;
          state_next = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_tick) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Load data extraction
  // ---------------------------------------------------------------
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = DDT[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? DDT[31:16] : DDT[15:0];

  always_comb begin
    case (size_reg)
      2'b10:   load_ext = {{24{sign_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sign_reg & half_sel[15]}}, half_sel};
      default: load_ext = DDT;
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      size_reg     <= '0;
      sign_reg     <= 1'b0;
      write_reg    <= 1'b0;
      rd_reg       <= '0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      misalign_reg <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      misalign_reg <= mis_pulse;

      if (alu_pass) begin
        wb_valid_reg <= 1'b1;
        wb_data_reg  <= ex_result;
        wb_rd_reg    <= ex_rd;
      end

      if (accept) begin
        addr_reg  <= ex_addr;
        wdata_reg <= store_lanes;
        size_reg  <= ex_size;
        sign_reg  <= ex_sign;
        write_reg <= ex_store;
        rd_reg    <= ex_rd;
      end

      // Load data is captured from DDT on the acknowledge edge itself.
      if (ack_done && !write_reg) begin
        wb_valid_reg <= 1'b1;
        wb_data_reg  <= load_ext;
        wb_rd_reg    <= rd_reg;
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign MREQ     = (state_reg == REQ);
  assign DAD      = addr_reg;
  assign WRITE    = write_reg;
  assign SIZE     = size_reg;
  assign DDT      = (state_reg == REQ && write_reg) ? wdata_reg : 32'hzzzz_zzzz;

  assign wb_valid = wb_valid_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;
  assign misalign = misalign_reg;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed testbench for mem_bus_unit. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_mem_bus_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_load;
  logic        ex_store;
  logic [1:0]  ex_size;
  logic        ex_sign;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_result;
  logic [4:0]  ex_rd;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;
  logic [31:0] DAD;
  wire  [31:0] DDT;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  // Bench-side bus driver (memory model / high-Z probe).
  logic        drv_en;
  logic [31:0] drv_val;
  assign DDT = drv_en ? drv_val : 32'hzzzz_zzzz;

  int errors = 0;
  int checks = 0;

  mem_bus_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_load   (ex_load),
    .ex_store  (ex_store),
    .ex_size   (ex_size),
    .ex_sign   (ex_sign),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_result (ex_result),
    .ex_rd     (ex_rd),
    .mem_stall (mem_stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .DAD       (DAD),
    .DDT       (DDT),
    .MREQ      (MREQ),
    .WRITE     (WRITE),
    .SIZE      (SIZE),
    .ACKD_n    (ACKD_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    ex_size   = 2'b00;
    ex_sign   = 1'b0;
    ex_addr   = '0;
    ex_wdata  = '0;
    ex_result = '0;
    ex_rd     = '0;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] res, input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_load   = ld;
    ex_store  = st;
    ex_size   = sz;
    ex_sign   = sg;
    ex_addr   = a;
    ex_wdata  = wd;
    ex_result = res;
    ex_rd     = rd;
  endtask

  // Load with acknowledge in the first REQ cycle (minimum latency).
  task automatic load_min(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] bus,
                          input logic [31:0] exp, input logic [4:0] rd);
    issue(1'b1, 1'b0, sz, sg, a, 32'h0, 32'h0, rd);
    ACKD_n = 1'b1;
    @(negedge clk);
    chk({tag, "_stall_acc"}, 32'(mem_stall), 32'd1);
    chk({tag, "_mreq_acc"}, 32'(MREQ), 32'd0);
    next_cycle();
    idle_in();
    ACKD_n  = 1'b0;
    drv_en  = 1'b1;
    drv_val = bus;
    @(negedge clk);
    chk({tag, "_mreq"}, 32'(MREQ), 32'd1);
    chk({tag, "_write"}, 32'(WRITE), 32'd0);
    chk({tag, "_size"}, 32'(SIZE), 32'(sz));
    chk({tag, "_dad"}, DAD, a);
    chk({tag, "_wbv_early"}, 32'(wb_valid), 32'd0);
    next_cycle();
    ACKD_n = 1'b1;
    drv_en = 1'b0;
    @(negedge clk);
    chk({tag, "_mreq_done"}, 32'(MREQ), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_stall_done"}, 32'(mem_stall), 32'd0);
    $display("txn %s addr=%h bus=%h wb_data=%h", tag, a, bus, wb_data);
    next_cycle();
    @(negedge clk);
    chk({tag, "_wbv_pulse"}, 32'(wb_valid), 32'd0);
    next_cycle();
  endtask

  initial begin
    rst     = 1'b1;
    ACKD_n  = 1'b1;
    drv_en  = 1'b0;
    drv_val = '0;
    idle_in();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mreq", 32'(MREQ), 32'd0);
    chk("rst_write", 32'(WRITE), 32'd0);
    chk("rst_size", 32'(SIZE), 32'd0);
    chk("rst_dad", DAD, 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbrd", 32'(wb_rd), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    $display("txn reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Loads with minimum latency
    load_min("ld_word", 2'b00, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd5);
    load_min("ld_sbyte", 2'b10, 1'b1, 32'h0000_0103, 32'h80FF_FFFF, 32'hFFFF_FF80, 5'd6);
    load_min("ld_ubyte", 2'b10, 1'b0, 32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0080, 5'd7);
    load_min("ld_shalf", 2'b01, 1'b1, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF, 5'd8);
    load_min("ld_ubyte1", 2'b10, 1'b0, 32'h0000_0101, 32'h1122_3344, 32'h0000_0033, 5'd9);

    // Half store with acknowledge delayed 3 cycles
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hABCD_1234, 32'h0, 5'd0);
    ACKD_n = 1'b1;
    @(negedge clk);
    chk("st_half_stall_acc", 32'(mem_stall), 32'd1);
    next_cycle();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      ACKD_n = (i == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("st_half_mreq%0d", i), 32'(MREQ), 32'd1);
      chk($sformatf("st_half_dad%0d", i), DAD, 32'h0000_0202);
      chk($sformatf("st_half_size%0d", i), 32'(SIZE), 32'd1);
      chk($sformatf("st_half_write%0d", i), 32'(WRITE), 32'd1);
      chk($sformatf("st_half_ddt%0d", i), DDT, 32'h1234_1234);
      chk($sformatf("st_half_stall%0d", i), 32'(mem_stall), 32'd1);
      next_cycle();
    end
    ACKD_n  = 1'b1;
    drv_en  = 1'b1;
    drv_val = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("st_half_hiz", DDT, 32'h5A5A_5A5A);
    chk("st_half_mreq_done", 32'(MREQ), 32'd0);
    chk("st_half_wbv", 32'(wb_valid), 32'd0);
    chk("st_half_stall_done", 32'(mem_stall), 32'd0);
    drv_en = 1'b0;
    $display("txn st_half addr=00000202");
    next_cycle();

    // Byte store, acknowledged in its first REQ cycle
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'h0000_00A7, 32'h0, 5'd0);
    next_cycle();
    idle_in();
    ACKD_n = 1'b0;
    @(negedge clk);
    chk("st_byte_ddt", DDT, 32'hA7A7_A7A7);
    chk("st_byte_size", 32'(SIZE), 32'd2);
    chk("st_byte_dad", DAD, 32'h0000_0301);
    next_cycle();
    ACKD_n = 1'b1;
    @(negedge clk);
    chk("st_byte_mreq_done", 32'(MREQ), 32'd0);
    chk("st_byte_wbv", 32'(wb_valid), 32'd0);
    $display("txn st_byte addr=00000301");
    next_cycle();

    // Misaligned word load, followed immediately by an ALU op
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    chk("mis_w_stall", 32'(mem_stall), 32'd0);
    next_cycle();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_55AA, 5'd7);
    @(negedge clk);
    chk("mis_w_pulse", 32'(misalign), 32'd1);
    chk("mis_w_mreq", 32'(MREQ), 32'd0);
    chk("mis_w_wbv", 32'(wb_valid), 32'd0);
    chk("alu_stall", 32'(mem_stall), 32'd0);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("alu_wbv", 32'(wb_valid), 32'd1);
    chk("alu_data", wb_data, 32'h0000_55AA);
    chk("alu_rd", 32'(wb_rd), 32'd7);
    chk("mis_w_pulse_end", 32'(misalign), 32'd0);
    $display("txn misaligned word + alu result=%h", wb_data);
    next_cycle();

    // Misaligned half load
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0, 32'h0, 5'd4);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("mis_h_pulse", 32'(misalign), 32'd1);
    chk("mis_h_mreq", 32'(MREQ), 32'd0);
    $display("txn misaligned half");
    next_cycle();

    // Acknowledge while idle is ignored
    ACKD_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("idle_ack_mreq", 32'(MREQ), 32'd0);
    chk("idle_ack_wbv", 32'(wb_valid), 32'd0);
    ACKD_n = 1'b1;
    $display("txn idle ack");
    next_cycle();

    // Reset in the 2nd REQ cycle with a simultaneous acknowledge
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 5'd9);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("rstreq_mreq1", 32'(MREQ), 32'd1);
    next_cycle();
    rst     = 1'b1;
    ACKD_n  = 1'b0;
    drv_en  = 1'b1;
    drv_val = 32'h1111_1111;
    @(negedge clk);
    chk("rstreq_mreq2", 32'(MREQ), 32'd1);
    next_cycle();
    rst     = 1'b0;
    ACKD_n  = 1'b1;
    drv_val = 32'hC3C3_C3C3;
    @(negedge clk);
    chk("rstreq_mreq_off", 32'(MREQ), 32'd0);
    chk("rstreq_wbv", 32'(wb_valid), 32'd0);
    chk("rstreq_wbdata", wb_data, 32'd0);
    chk("rstreq_hiz", DDT, 32'hC3C3_C3C3);
    drv_en = 1'b0;
    $display("txn reset during REQ");
    next_cycle();

`ifdef MEM_TIMEOUT_EN
    // Timeout after 4 REQ cycles without acknowledge
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 5'd10);
    next_cycle();
    idle_in();
    ACKD_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_mreq%0d", i), 32'(MREQ), 32'd1);
      chk($sformatf("tmo_buserr%0d", i), 32'(bus_err), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("tmo_mreq_off", 32'(MREQ), 32'd0);
    chk("tmo_buserr", 32'(bus_err), 32'd1);
    chk("tmo_stall", 32'(mem_stall), 32'd0);
    chk("tmo_wbv", 32'(wb_valid), 32'd0);
    $display("txn timeout");
    next_cycle();
`else
    chk("buserr_tied", 32'(bus_err), 32'd0);
`endif

    // ALU op after everything, to confirm normal operation
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 5'd31);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("alu2_wbv", 32'(wb_valid), 32'd1);
    chk("alu2_data", wb_data, 32'h1357_9BDF);
    chk("alu2_rd", 32'(wb_rd), 32'd31);
    $display("txn alu result=%h", wb_data);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_unit.md
Name: mem_bus_unit

Overview:
MEM-stage data bus unit of the pipelined core; sits between the EX/MEM pipeline register and the external data bus.
- Runs one load/store bus cycle per memory instruction on DAD/DDT/MREQ/WRITE/SIZE, waiting for the active-low acknowledge ACKD_n.
- Aligns store data onto byte lanes and extracts/extends load data.
- Hands the result to WB and stalls upstream stages while the bus is busy.

Parameters:
TIMEOUT, 16, max cycles MREQ may stay high without ACKD_n (only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  single core clock, all state on rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX/MEM register holds a valid instruction
ex_load  in  1  instruction is a load
ex_store  in  1  instruction is a store
ex_size  in  2  00 word, 01 half, 10 byte (11 treated as word)
ex_sign  in  1  load result is sign-extended (else zero-extended)
ex_addr  in  32  effective address
ex_wdata  in  32  store data, right-justified
ex_result  in  32  ALU result for non-memory instructions
ex_rd  in  5  destination register
mem_stall  out  1  hold IF/ID/EX stages
wb_valid  out  1  one-cycle pulse, result valid
wb_rd  out  5  destination register for WB
wb_data  out  32  load data or passed-through ALU result
misalign  out  1  one-cycle pulse, misaligned access rejected
bus_err  out  1  one-cycle pulse, bus timeout (MEM_TIMEOUT_EN only, else tied 0)
DAD  out  32  data bus address
DDT  inout  32  data bus data
MREQ  out  1  bus request, active high
WRITE  out  1  1 store, 0 load
SIZE  out  2  same encoding as ex_size
ACKD_n  in  1  bus acknowledge, active low

Behaviour:
- Reset values: MREQ=0, WRITE=0, SIZE=00, DAD=0, wb_valid=0, wb_rd=0, wb_data=0, misalign=0, bus_err=0. DDT is high-Z. State = IDLE.
- States: IDLE, REQ.
- IDLE with ex_valid and neither load nor store:
  - Next cycle: wb_valid=1, wb_data=ex_result, wb_rd=ex_rd.
  - mem_stall=0.
- IDLE with ex_valid and load or store, aligned:
  - Register address, store data, size, sign and rd; enter REQ.
  - mem_stall=1 combinationally in this accept cycle.
- Alignment rules:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=00 is misaligned.
  - Misaligned access: no bus cycle, misalign=1 next cycle, wb_valid stays 0, mem_stall=0.
- REQ:
  - MREQ=1; DAD = {addr[31:2], addr[1:0]} held stable; WRITE and SIZE held stable.
  - mem_stall=1.
  - Stays in REQ while ACKD_n=1.
- ACKD_n=0 sampled at a rising edge in REQ:
  - Return to IDLE; MREQ=0 from the next cycle.
  - Load: capture DDT at that edge, wb_valid=1 for one cycle.
  - Store: wb_valid=0.
  - mem_stall falls in the cycle after the ack edge.
- Minimum load latency: accept in cycle 0, MREQ in cycle 1, ack sampled at end of cycle 1, wb_valid in cycle 2.
- Byte lanes, little-endian: byte k of the word sits on DDT[8k+7:8k] with k = addr[1:0].
- Store drive:
  - Byte data replicated on all 4 lanes; half data replicated on both halves; word as is.
  - DDT driven only while state=REQ and WRITE=1, otherwise high-Z.
- Load extract:
  - Byte: lane addr[1:0]. Half: lane pair addr[1].
  - Sign- or zero-extended per the registered sign bit.
- ACKD_n=0 while IDLE is ignored.
- Only one outstanding access; back-to-back memory ops give MREQ low for at least 1 cycle between them.
- rst mid-REQ: next edge forces IDLE, MREQ=0, DDT high-Z, no wb_valid; a simultaneous ack is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT with ACKD_n still 1: return to IDLE, MREQ=0, bus_err=1 for one cycle, no wb_valid.
  - An ack on the same edge as the timeout wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; bus_err is constant 0.

Test Plan:
- Word load, addr 0x100, ACKD_n low first REQ cycle, DDT=0xDEADBEEF -> MREQ high 1 cycle, WRITE=0, SIZE=00, wb_valid cycle 2 with 0xDEADBEEF.
- Signed byte load, addr 0x103, DDT=0x80FFFFFF -> wb_data=0xFFFFFF80; unsigned variant -> 0x00000080.
- Half store 0x1234 to 0x202, ACKD_n delayed 3 cycles -> MREQ/DAD/SIZE=01 stable 4 cycles, DDT=0x12341234, mem_stall high throughout, high-Z after.
- Word load at 0x101 -> no MREQ, misalign pulse, no wb_valid; following ALU op passes with 1-cycle latency.
- rst asserted in 2nd REQ cycle with ACKD_n=0 -> MREQ 0 next cycle, no wb_valid, DDT high-Z.
- With MEM_TIMEOUT_EN, TIMEOUT=4, ACKD_n held 1 -> MREQ drops after 4 REQ cycles, bus_err pulse, mem_stall released.
